periph_input_ctrl: RTL and testbench

//  Input-side peripheral controller; the reader counterpart of the LED output device.
//  - Synchronises and debounces slide switches and push-buttons.
//  - Latches button-press events.
//  - Returns data to the CPU on perf_bus; the register-file writeback selects it with mem_to_reg=2'b11.
//  - Decodes the same device/command fields (instr[15:11], instr[5:0]) as the LED device.

---
 rtl/periph_input_ctrl.sv | 148 ++++++++++++++
 tb/tb_periph_input_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/periph_input_ctrl.sv
// rtl/periph_input_ctrl.sv - debounced switch/button reader with latched press events
// Answers CPU reads/writes on perf_bus when the decoded device number matches DEV_ID.
module periph_input_ctrl #(
  parameter logic [4:0] DEV_ID       = 5'd2,
  parameter int         SW_W         = 8,
  parameter int         BTN_W        = 4,
  parameter int         DEBOUNCE_CYC = 50000
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [SW_W-1:0]  i_sw_in,
  input  logic [BTN_W-1:0] i_btn_in,
  input  logic             i_rd_en,
  input  logic             i_wr_en,
  input  logic [4:0]       i_device,
  input  logic [5:0]       i_command,
  input  logic [31:0]      i_data_in,
  output logic [31:0]      o_perf_bus,
  output logic             o_irq,
  output logic [7:0]       o_press_cnt
);

  localparam int N     = SW_W + BTN_W;
  localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);

  localparam logic [5:0] CMD_RD_SW     = 6'h00;
  localparam logic [5:0] CMD_RD_BTN    = 6'h01;
  localparam logic [5:0] CMD_RD_EVT    = 6'h02;
  localparam logic [5:0] CMD_RD_STAT   = 6'h03;
  localparam logic [5:0] CMD_WR_IRQEN  = 6'h04;
  localparam logic [5:0] CMD_WR_CLRCNT = 6'h05;

  logic [N-1:0]     w_raw;
  logic [N-1:0]     r_sync1;
  logic [N-1:0]     r_sync2;
  logic [N-1:0]     r_stable;
  logic [N-1:0]     w_flip;
  logic [SW_W-1:0]  w_sw_db;
  logic [BTN_W-1:0] w_btn_db;
  logic [BTN_W-1:0] w_btn_rise;
  logic [BTN_W-1:0] r_btn_evt;
  logic [BTN_W-1:0] w_evt_next;
  logic [8:0]       w_rise_cnt;
  logic [8:0]       w_cnt_base;
  logic [8:0]       w_cnt_sum;
  logic [7:0]       w_cnt_next;
  logic [7:0]       r_press_cnt;
  logic             r_irq_en;
  logic             r_irq;
  logic             w_sel;
  logic             w_rd;
  logic             w_wr;
  logic             w_rd_evt;
  logic             w_wr_irqen;
  logic             w_clrcnt;
  logic             w_unused;

  assign w_raw    = {i_btn_in, i_sw_in};
  assign w_unused = ^i_data_in[31:1];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_stable <= '0;
    end else begin
      r_sync1  <= w_raw;
      r_sync2  <= r_sync1;
      r_stable <= r_stable ^ w_flip;
    end
  end

  // One stability counter per bit; the level is accepted on the edge the count hits its limit.
  for (genvar gi = 0; gi < N; gi++) begin : g_db
    logic [CNT_W-1:0] r_cnt;

    assign w_flip[gi] = (r_sync2[gi] != r_stable[gi]) && (r_cnt == CNT_MAX);

    always_ff @(posedge i_clk) begin
      if (i_reset) begin
        r_cnt <= '0;
      end else if ((r_sync2[gi] == r_stable[gi]) || w_flip[gi]) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign w_sw_db    = r_stable[SW_W-1:0];
  assign w_btn_db   = r_stable[N-1:SW_W];
  assign w_btn_rise = w_flip[N-1:SW_W] & ~w_btn_db;

  assign w_sel      = (i_device == DEV_ID);
  assign w_rd       = i_rd_en & w_sel;
  assign w_wr       = i_wr_en & w_sel;
  assign w_rd_evt   = w_rd && (i_command == CMD_RD_EVT);
  assign w_wr_irqen = w_wr && (i_command == CMD_WR_IRQEN);
  assign w_clrcnt   = w_wr && (i_command == CMD_WR_CLRCNT);

  // A press landing on the read-to-clear edge survives the clear.
  assign w_evt_next = (w_rd_evt ? '0 : r_btn_evt) | w_btn_rise;

  always_comb begin
    w_rise_cnt = '0;
    for (int i = 0; i < BTN_W; i++) begin
      w_rise_cnt = w_rise_cnt + 9'(w_btn_rise[i]);
    end
  end

  assign w_cnt_base = w_clrcnt ? 9'd0 : {1'b0, r_press_cnt};
  assign w_cnt_sum  = w_cnt_base + w_rise_cnt;
  assign w_cnt_next = w_cnt_sum[8] ? 8'hFF : w_cnt_sum[7:0];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_btn_evt   <= '0;
      r_press_cnt <= '0;
      r_irq_en    <= 1'b0;
      r_irq       <= 1'b0;
    end else begin
      r_btn_evt   <= w_evt_next;
      r_press_cnt <= w_cnt_next;
      if (w_wr_irqen) begin
        r_irq_en <= i_data_in[0];
      end
      r_irq       <= r_irq_en & (|w_evt_next);
    end
  end

  always_comb begin
    o_perf_bus = 32'h0;
    if (!i_reset && w_rd) begin
      case (i_command)
        CMD_RD_SW:   o_perf_bus = 32'(w_sw_db);
        CMD_RD_BTN:  o_perf_bus = 32'(w_btn_db);
        CMD_RD_EVT:  o_perf_bus = 32'(r_btn_evt);
        CMD_RD_STAT: o_perf_bus = {16'b0, r_press_cnt, 7'b0, r_irq_en};
        default:     o_perf_bus = 32'h0;
      endcase
    end
  end

  assign o_irq       = r_irq;
  assign o_press_cnt = r_press_cnt;

endmodule

// File: tb/tb_periph_input_ctrl.sv
// tb/tb_periph_input_ctrl.sv - directed bench for periph_input_ctrl (DEBOUNCE_CYC=4, DEV_ID=2)
module tb_periph_input_ctrl;

  logic        clk;
  logic        reset;
  logic [7:0]  sw_in;
  logic [3:0]  btn_in;
  logic        rd_en;
  logic        wr_en;
  logic [4:0]  device;
  logic [5:0]  command;
  logic [31:0] data_in;
  logic [31:0] perf_bus;
  logic        irq;
  logic [7:0]  press_cnt;

  int n_cmp;
  int n_fail;

  periph_input_ctrl #(
    .DEV_ID      (5'd2),
    .SW_W        (8),
    .BTN_W       (4),
    .DEBOUNCE_CYC(4)
  ) dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_sw_in    (sw_in),
    .i_btn_in   (btn_in),
    .i_rd_en    (rd_en),
    .i_wr_en    (wr_en),
    .i_device   (device),
    .i_command  (command),
    .i_data_in  (data_in),
    .o_perf_bus (perf_bus),
    .o_irq      (irq),
    .o_press_cnt(press_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus(input logic rd, input logic wr, input logic [4:0] dev,
                     input logic [5:0] cmd, input logic [31:0] data);
    rd_en   = rd;
    wr_en   = wr;
    device  = dev;
    command = cmd;
    data_in = data;
    #1;
  endtask

  task automatic idle();
    bus(1'b0, 1'b0, 5'd0, 6'h00, 32'h0);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    reset  = 1'b1;
    sw_in  = 8'h00;
    btn_in = 4'h0;
    idle();
    tick(3);
    reset = 1'b0;
    tick(1);

    // reset state
    bus(1'b1, 1'b0, 5'd2, 6'h03, 32'h0);
    check("rst_stat", perf_bus, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    check("rst_cnt", {24'b0, press_cnt}, 32'h0);
    idle();

    // 1: switches
    sw_in = 8'hA5;
    tick(10);
    bus(1'b1, 1'b0, 5'd2, 6'h00, 32'h0);
    check("rd_sw_dev2", perf_bus, 32'h000000A5);
    bus(1'b1, 1'b0, 5'd3, 6'h00, 32'h0);
    check("rd_sw_dev3", perf_bus, 32'h0);
    bus(1'b0, 1'b0, 5'd2, 6'h00, 32'h0);
    check("rd_sw_norden", perf_bus, 32'h0);
    bus(1'b1, 1'b0, 5'd2, 6'h3F, 32'h0);
    check("rd_badcmd", perf_bus, 32'h0);
    idle();

    // 2: glitch rejected, then a real press on btn[1]
    btn_in = 4'h2;
    tick(2);
    btn_in = 4'h0;
    tick(8);
    bus(1'b1, 1'b0, 5'd2, 6'h01, 32'h0);
    check("glitch_btn", perf_bus, 32'h0);
    bus(1'b1, 1'b0, 5'd2, 6'h02, 32'h0);
    check("glitch_evt", perf_bus, 32'h0);
    check("glitch_cnt", {24'b0, press_cnt}, 32'h0);
    idle();
    btn_in = 4'h2;
    tick(5);
    bus(1'b1, 1'b0, 5'd2, 6'h01, 32'h0);
    check("btn_db_5cyc", perf_bus, 32'h0);
    idle();
    tick(1);
    bus(1'b1, 1'b0, 5'd2, 6'h01, 32'h0);
    check("btn_db_6cyc", perf_bus, 32'h2);
    btn_in = 4'h0;
    bus(1'b1, 1'b0, 5'd2, 6'h02, 32'h0);
    check("rd_evt_1", perf_bus, 32'h2);
    tick(1);
    check("rd_evt_2", perf_bus, 32'h0);
    idle();
    check("cnt_after_1", {24'b0, press_cnt}, 32'h1);

    // 3: interrupt
    bus(1'b0, 1'b1, 5'd2, 6'h04, 32'h1);
    tick(1);
    idle();
    check("irq_no_evt", {31'b0, irq}, 32'h0);
    bus(1'b1, 1'b0, 5'd2, 6'h03, 32'h0);
    check("stat_irqen", perf_bus, 32'h00000101);
    idle();
    btn_in = 4'h1;
    tick(7);
    check("irq_set", {31'b0, irq}, 32'h1);
    bus(1'b1, 1'b0, 5'd2, 6'h02, 32'h0);
    check("evt_btn0", perf_bus, 32'h1);
    tick(1);
    idle();
    check("irq_clr", {31'b0, irq}, 32'h0);
    btn_in = 4'h0;
    tick(8);

    // 4: press lands on the read-to-clear edge
    btn_in = 4'h8;
    tick(5);
    bus(1'b1, 1'b0, 5'd2, 6'h02, 32'h0);
    check("evt_pre_edge", perf_bus, 32'h0);
    tick(1);
    idle();
    bus(1'b1, 1'b0, 5'd2, 6'h02, 32'h0);
    check("evt_set_wins", perf_bus, 32'h8);
    idle();
    check("irq_set_wins", {31'b0, irq}, 32'h1);
    check("cnt_after_3", {24'b0, press_cnt}, 32'h3);
    btn_in = 4'h0;
    tick(8);

    // 5: saturation on btn[2]
    for (int n = 1; n <= 260; n++) begin
      btn_in = 4'h4;
      tick(6);
      btn_in = 4'h0;
      tick(6);
      if (n == 251) check("cnt_254", {24'b0, press_cnt}, 32'hFE);
      if (n == 252) check("cnt_255", {24'b0, press_cnt}, 32'hFF);
    end
    check("cnt_sat", {24'b0, press_cnt}, 32'hFF);
    bus(1'b1, 1'b0, 5'd2, 6'h03, 32'h0);
    check("stat_sat", perf_bus, 32'h0000FF01);
    bus(1'b0, 1'b1, 5'd3, 6'h05, 32'h0);
    tick(1);
    check("clr_dev3", {24'b0, press_cnt}, 32'hFF);
    bus(1'b0, 1'b1, 5'd2, 6'h05, 32'h0);
    tick(1);
    check("clr_dev2", {24'b0, press_cnt}, 32'h0);
    bus(1'b1, 1'b0, 5'd2, 6'h03, 32'h0);
    check("stat_clr", perf_bus, 32'h00000001);

    // 6: simultaneous presses with clear, then reset mid-debounce
    bus(1'b1, 1'b0, 5'd2, 6'h02, 32'h0);
    tick(1);
    idle();
    btn_in = 4'h3;
    tick(5);
    bus(1'b0, 1'b1, 5'd2, 6'h05, 32'h0);
    tick(1);
    idle();
    check("clr_plus_2", {24'b0, press_cnt}, 32'h2);
    bus(1'b1, 1'b0, 5'd2, 6'h02, 32'h0);
    check("evt_3", perf_bus, 32'h3);
    idle();
    btn_in = 4'hB;
    tick(4);
    reset = 1'b1;
    bus(1'b1, 1'b0, 5'd2, 6'h03, 32'h0);
    check("rst_bus_comb", perf_bus, 32'h0);
    tick(1);
    check("rst_bus", perf_bus, 32'h0);
    check("rst_irq2", {31'b0, irq}, 32'h0);
    check("rst_cnt2", {24'b0, press_cnt}, 32'h0);
    reset = 1'b0;
    idle();
    tick(5);
    bus(1'b1, 1'b0, 5'd2, 6'h01, 32'h0);
    check("held_5cyc", perf_bus, 32'h0);
    idle();
    tick(1);
    bus(1'b1, 1'b0, 5'd2, 6'h01, 32'h0);
    check("held_6cyc", perf_bus, 32'hB);
    bus(1'b1, 1'b0, 5'd2, 6'h02, 32'h0);
    check("held_evt", perf_bus, 32'hB);
    bus(1'b1, 1'b0, 5'd2, 6'h03, 32'h0);
    check("held_stat", perf_bus, 32'h00000300);
    idle();
    check("held_irq", {31'b0, irq}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
